bcd_converter: RTL and testbench

Sequential binary-to-BCD converter (shift-and-add-3, "double dabble") that turns a binary value into four BCD digits for the four-digit seven-segment display path. It sits directly upstream of the display digit multiplexer: its four digit outputs feed the per-digit inputs that the refresh logic selects and sends to the cathode decoder. Conversion is started by a single-cycle handshake, takes a fixed number of cycles, and the digit outputs hold the last completed result so the display never shows intermediate values.

---
 rtl/bcd_converter.sv | 104 ++++++++++
 tb/tb_bcd_converter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_converter.sv
// Sequential shift-and-add-3 binary-to-BCD converter feeding the four-digit display mux.
// Digit outputs hold the last completed result; values above 9999 saturate to 9999.
module bcd_converter #(
  parameter int BINARY_WIDTH = 14
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [BINARY_WIDTH-1:0] binary,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [3:0]              digit_1,
  output logic [3:0]              digit_2,
  output logic [3:0]              digit_3,
  output logic [3:0]              digit_4
);

  localparam int WW = BINARY_WIDTH + 16;
  localparam int CW = $clog2(BINARY_WIDTH + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] LOAD  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [WW-1:0] work_q, work_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flag_q, flag_d;
  logic [15:0]   digits_q, digits_d;
  logic          overflow_q, overflow_d;
  logic          done_q, done_d;
  logic [WW-1:0] adj;

  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    cnt_d      = cnt_q;
    flag_d     = flag_q;
    digits_d   = digits_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;

    // BCD nibbles sit above the binary field; correct each before the shift
    adj = work_q;
    for (int unsigned k = 0; k < 4; k++) begin
      if (work_q[BINARY_WIDTH + 4*k +: 4] >= 4'd5)
        adj[BINARY_WIDTH + 4*k +: 4] = work_q[BINARY_WIDTH + 4*k +: 4] + 4'd3;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          work_d  = {16'b0, binary};
          cnt_d   = '0;
          flag_d  = (32'(binary) > 32'd9999);
        end
      end
      SHIFT: begin
        work_d = {adj[WW-2:0], 1'b0};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(BINARY_WIDTH - 1))
          state_d = LOAD;
      end
      LOAD: begin
        digits_d   = flag_q ? 16'h9999 : work_q[WW-1 -: 16];
        overflow_d = flag_q;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      work_q     <= '0;
      cnt_q      <= '0;
      flag_q     <= 1'b0;
      digits_q   <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      cnt_q      <= cnt_d;
      flag_q     <= flag_d;
      digits_q   <= digits_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign overflow = overflow_q;
  assign digit_1  = digits_q[3:0];
  assign digit_2  = digits_q[7:4];
  assign digit_3  = digits_q[11:8];
  assign digit_4  = digits_q[15:12];

endmodule

// File: tb/tb_bcd_converter.sv
// Directed bench for bcd_converter at widths 14 and 4, checked against a divide/modulo model.
module tb_bcd_converter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start, start4;
  logic [13:0] binary;
  logic [3:0]  binary4;
  logic        busy, done, overflow;
  logic [3:0]  digit_1, digit_2, digit_3, digit_4;
  logic        busy4, done4, overflow4;
  logic [3:0]  d4_1, d4_2, d4_3, d4_4;
  logic [15:0] d14, d4;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  bcd_converter #(.BINARY_WIDTH(14)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .binary(binary),
    .busy(busy), .done(done), .overflow(overflow),
    .digit_1(digit_1), .digit_2(digit_2), .digit_3(digit_3), .digit_4(digit_4)
  );

  bcd_converter #(.BINARY_WIDTH(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .start(start4), .binary(binary4),
    .busy(busy4), .done(done4), .overflow(overflow4),
    .digit_1(d4_1), .digit_2(d4_2), .digit_3(d4_3), .digit_4(d4_4)
  );

  assign d14 = {digit_4, digit_3, digit_2, digit_1};
  assign d4  = {d4_4, d4_3, d4_2, d4_1};

  // {overflow, thousands, hundreds, tens, ones}
  function automatic logic [16:0] model(input int v);
    if (v > 9999) return {1'b1, 16'h9999};
    return {1'b0, 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Pulses start for one edge, scrambles binary afterwards, waits for done.
  // cycles = edges after the accepting edge until done is seen.
  task automatic run14(input int v, output int cycles, output int busy_cycles);
    @(negedge clock);
    start  = 1'b1;
    binary = 14'(v);
    @(negedge clock);
    start  = 1'b0;
    binary = ~binary;
    cycles = 0;
    busy_cycles = 0;
    while (done !== 1'b1 && cycles < 40) begin
      if (busy === 1'b1) busy_cycles++;
      @(negedge clock);
      cycles++;
    end
  endtask

  task automatic run4(input int v, output int cycles);
    @(negedge clock);
    start4  = 1'b1;
    binary4 = 4'(v);
    @(negedge clock);
    start4  = 1'b0;
    binary4 = ~binary4;
    cycles = 0;
    while (done4 !== 1'b1 && cycles < 20) begin
      @(negedge clock);
      cycles++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0; start4 = 1'b0; binary = '0; binary4 = '0;
    #12;
    total++;
    if ({busy, done, overflow, d14} !== 19'd0)
      $display("FAIL reset_w14 got busy=%b done=%b ovf=%b digits=%h want all 0", busy, done, overflow, d14);
    else passed++;
    total++;
    if ({busy4, done4, overflow4, d4} !== 19'd0)
      $display("FAIL reset_w4 got busy=%b done=%b ovf=%b digits=%h want all 0", busy4, done4, overflow4, d4);
    else passed++;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_zero();
    int cyc, bcyc;
    run14(0, cyc, bcyc);
    total++;
    if (cyc !== 15 || bcyc !== 15 || busy !== 1'b0)
      $display("FAIL zero_latency got done_at=%0d busy_cycles=%0d busy=%b want 15 15 0", cyc, bcyc, busy);
    else passed++;
    total++;
    if ({overflow, d14} !== model(0))
      $display("FAIL zero_digits got %h want %h", {overflow, d14}, model(0));
    else passed++;
    @(negedge clock);
    total++;
    if (done !== 1'b0)
      $display("FAIL done_width got done=%b one cycle later want 0", done);
    else passed++;
  endtask

  task automatic test_digits();
    int vals[6] = '{1234, 9999, 10, 10000, 16383, 42};
    int cyc, bcyc;
    foreach (vals[i]) begin
      run14(vals[i], cyc, bcyc);
      total++;
      if (cyc !== 15 || {overflow, d14} !== model(vals[i]))
        $display("FAIL digits_%0d got done_at=%0d ovf_digits=%h want 15 %h",
                 vals[i], cyc, {overflow, d14}, model(vals[i]));
      else passed++;
    end
  endtask

  task automatic test_ignore_start();
    int cyc, bcyc, ndone, done_at;
    bit held;
    run14(1234, cyc, bcyc);
    @(negedge clock);
    start = 1'b1; binary = 14'd5678;
    @(negedge clock);               // after E0
    start = 1'b0;
    @(negedge clock);               // after E1
    @(negedge clock);               // after E2
    start = 1'b1; binary = 14'd1111;
    @(negedge clock);               // after E3
    start = 1'b0;
    ndone = 0; done_at = -1; held = 1'b1;
    for (int c = 3; c < 40; c++) begin
      if (done === 1'b1) begin
        ndone++;
        if (done_at < 0) done_at = c;
      end
      if (ndone == 0 && {overflow, d14} !== model(1234)) held = 1'b0;
      @(negedge clock);
    end
    total++;
    if (!held)
      $display("FAIL hold_prev_digits got %h before load want %h", {overflow, d14}, model(1234));
    else passed++;
    total++;
    if (ndone !== 1 || done_at !== 15 || busy !== 1'b0)
      $display("FAIL ignored_start got dones=%0d first_at=%0d busy=%b want 1 15 0", ndone, done_at, busy);
    else passed++;
    total++;
    if ({overflow, d14} !== model(5678))
      $display("FAIL ignored_start_digits got %h want %h", {overflow, d14}, model(5678));
    else passed++;
  endtask

  task automatic test_reset_mid();
    int cyc, bcyc;
    bit saw_done;
    @(negedge clock);
    start = 1'b1; binary = 14'd4321;
    @(negedge clock);
    start = 1'b0;
    repeat (6) @(negedge clock);
    @(posedge clock);               // E7
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({busy, done, overflow, d14} !== 19'd0)
      $display("FAIL reset_mid got busy=%b done=%b ovf=%b digits=%h want all 0", busy, done, overflow, d14);
    else passed++;
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (done !== 1'b0) saw_done = 1'b1;
    end
    reset_n = 1'b1;
    repeat (20) begin
      @(negedge clock);
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
    end
    total++;
    if (saw_done)
      $display("FAIL reset_mid_no_done got activity after abort want none");
    else passed++;
    run14(4321, cyc, bcyc);
    total++;
    if (cyc !== 15 || {overflow, d14} !== model(4321))
      $display("FAIL after_reset got done_at=%0d digits=%h want 15 %h", cyc, {overflow, d14}, model(4321));
    else passed++;
  endtask

  task automatic test_back_to_back();
    int nd = 0;
    bit ok = 1'b1;
    for (int i = 0; i <= 112; i++) begin
      @(negedge clock);
      if (i > 0) begin
        if (busy === 1'b1 && done === 1'b1) ok = 1'b0;
        if (done === 1'b1) begin
          total++;
          if ((i - 1) !== 16 * nd + 15 || {overflow, d14} !== model(16 * nd))
            $display("FAIL b2b_%0d got edge=%0d digits=%h want edge=%0d digits=%h",
                     nd, i - 1, {overflow, d14}, 16 * nd + 15, model(16 * nd));
          else passed++;
          nd++;
        end
      end
      if (i < 112) begin
        start  = 1'b1;
        binary = 14'(i);
      end else start = 1'b0;
    end
    total++;
    if (nd !== 7 || !ok)
      $display("FAIL b2b_count got conversions=%0d busy_done_clean=%b want 7 1", nd, ok);
    else passed++;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_sweep();
    int cyc, bcyc;
    int edge_vals[6] = '{9998, 9999, 10000, 10001, 16382, 16383};
    for (int v = 0; v < 16384; v += 7) begin
      run14(v, cyc, bcyc);
      total++;
      if (cyc !== 15 || {overflow, d14} !== model(v))
        $display("FAIL sweep_%0d got done_at=%0d digits=%h want 15 %h", v, cyc, {overflow, d14}, model(v));
      else passed++;
    end
    foreach (edge_vals[i]) begin
      run14(edge_vals[i], cyc, bcyc);
      total++;
      if (cyc !== 15 || {overflow, d14} !== model(edge_vals[i]))
        $display("FAIL boundary_%0d got done_at=%0d digits=%h want 15 %h",
                 edge_vals[i], cyc, {overflow, d14}, model(edge_vals[i]));
      else passed++;
    end
  endtask

  task automatic test_width4();
    int cyc;
    for (int v = 0; v < 16; v++) begin
      run4(v, cyc);
      total++;
      if (cyc !== 5 || {overflow4, d4} !== model(v))
        $display("FAIL w4_%0d got done_at=%0d digits=%h want 5 %h", v, cyc, {overflow4, d4}, model(v));
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_digits();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
    test_width4();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
